// File: rtl/icache_fetch_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder and its tag array.
package icache_fetch_responder_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_WAIT = 2'd1,
        FILL      = 2'd2
    } state_e;

    localparam int OFFSET_BITS = 2;
    localparam int LINE_WORDS  = 4;
    localparam int LINE_BITS   = 64;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    function automatic logic [15:0] line_word(input logic [LINE_BITS-1:0] line,
                                              input logic [OFFSET_BITS-1:0] off);
        return line[{off, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/icache_fetch_responder_tag_array.sv
// Valid bits and tags for the direct-mapped cache, plus the single-port hit compare.
module icache_tag_array #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    input  logic [TAG_BITS-1:0]   rd_tag_i,
    output logic                  hit_o,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_index_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q [LINES];

    // A fill landing on the same edge as a flush survives it: set after clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (flush_i) valid_q <= '0;
            if (wr_en_i) valid_q[wr_index_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) tag_q[wr_index_i] <= wr_tag_i;
    end

    assign hit_o = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);

endmodule

// File: rtl/icache_fetch_responder.sv
// Instruction-fetch responder: direct-mapped I-cache with single-line refill FSM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
//
// state     | meaning
// IDLE      | lookup each cycle; a miss latches the line address
// MISS_WAIT | mem_re held high until mem_rdy captures the line
// FILL      | line buffer written into data/tag arrays, line set valid
module icache_fetch_responder
    import icache_fetch_responder_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int MEM_AW     = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       addr,
    input  logic              rd_en,
    input  logic              flush,
    output logic [15:0]       instr,
    output logic              stall,
    output logic              mem_re,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_rdy,
    input  logic [63:0]       mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int TAG_BITS = 16 - OFFSET_BITS - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    state_e                state_q;
    logic                  mem_re_q;
    logic [MEM_AW-1:0]     line_q;
    logic [LINE_BITS-1:0]  line_buf_q;
    logic [LINE_BITS-1:0]  data_q [LINES];

    logic [INDEX_BITS-1:0]  lk_index;
    logic [TAG_BITS-1:0]    lk_tag;
    logic [OFFSET_BITS-1:0] lk_off;
    logic                   hit;
    logic                   miss_start;
    logic                   fill_we;

    assign lk_off     = addr[OFFSET_BITS-1:0];
    assign lk_index   = addr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign lk_tag     = addr[15:INDEX_BITS+OFFSET_BITS];
    assign miss_start = (state_q == IDLE) && rd_en && !hit;
    assign fill_we    = (state_q == FILL);

    icache_tag_array #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_tags (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_index_i(lk_index),
        .rd_tag_i  (lk_tag),
        .hit_o     (hit),
        .flush_i   (flush),
        .wr_en_i   (fill_we),
        .wr_index_i(line_q[INDEX_BITS-1:0]),
        .wr_tag_i  (line_q[MEM_AW-1:INDEX_BITS])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mem_re_q <= 1'b0;
            line_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_start) begin
                        line_q   <= addr[15:OFFSET_BITS];
                        mem_re_q <= 1'b1;
                        state_q  <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (mem_rdy) begin
                        mem_re_q <= 1'b0;
                        state_q  <= FILL;
                    end
                end
                FILL: begin
                    state_q <= IDLE;
                end
                default: begin
                    mem_re_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // Data storage carries no reset; contents are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (state_q == MISS_WAIT && mem_rdy) line_buf_q <= mem_data;
        if (fill_we) data_q[line_q[INDEX_BITS-1:0]] <= line_buf_q;
    end

    assign stall    = rd_en && ((state_q != IDLE) || !hit);
    assign instr    = (rd_en && !stall) ? line_word(data_q[lk_index], lk_off) : NOP_INSTR;
    assign mem_re   = mem_re_q;
    assign mem_addr = line_q;

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && rd_en && hit && hit_cnt_q != 16'hFFFF)
                hit_cnt_q <= hit_cnt_q + 16'd1;
            if (miss_start && miss_cnt_q != 16'hFFFF)
                miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Randomized self-checking bench for icache_fetch_responder against a line-level cache model.
module tb_icache_fetch_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = '0;
    logic        rd_en = 1'b0;
    logic        flush = 1'b0;
    logic        mem_rdy = 1'b0;
    logic [63:0] mem_data = '0;
    logic [15:0] instr;
    logic        stall;
    logic        mem_re;
    logic [13:0] mem_addr;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    icache_fetch_responder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .rd_en   (rd_en),
        .flush   (flush),
        .instr   (instr),
        .stall   (stall),
        .mem_re  (mem_re),
        .mem_addr(mem_addr),
        .mem_rdy (mem_rdy),
        .mem_data(mem_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt)
`endif
    );

    // Reference model: what each cache slot currently holds, and the backing memory.
    bit          mv [8];
    logic [10:0] mt [8];
    logic [63:0] md [8];
    logic [63:0] mem_model [int];
    int          m_hits = 0;
    int          m_misses = 0;

    function automatic logic [63:0] mem_line(input int la);
        if (!mem_model.exists(la)) mem_model[la] = {$urandom, $urandom};
        return mem_model[la];
    endfunction

    task automatic model_clear_valid();
        for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    endtask

    // One fetch; d = number of MISS_WAIT cycles before mem_rdy, fl_pos = stall cycle carrying flush.
    task automatic access(input logic [15:0] a, input int d, input int fl_pos);
        int          idx = int'(a[4:2]);
        int          off = int'(a[1:0]);
        int          la  = int'(a[15:2]);
        logic [10:0] tg  = a[15:5];
        bit          exp_hit = mv[idx] && (mt[idx] == tg);
        int          sc = 0;
        int          rc = 0;
        logic [63:0] ln;
        logic [15:0] w;
        @(negedge clk);
        rd_en = 1'b1; addr = a; flush = (fl_pos == 1); mem_rdy = 1'b0;
        #1;
        if (exp_hit) begin
            w = md[idx][off*16 +: 16];
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hit_stall addr=%h got=%b exp=0", a, stall); end
            checks++; if (instr !== w) begin errors++; $display("FAIL hit_instr addr=%h got=%h exp=%h", a, instr, w); end
            checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL hit_mem_re addr=%h got=%b exp=0", a, mem_re); end
            m_hits++;
            if (fl_pos == 1) model_clear_valid();
            return;
        end
        ln = mem_line(la);
        w  = ln[off*16 +: 16];
        while (stall === 1'b1 && sc < 50) begin
            sc++;
            if (mem_re === 1'b1) begin
                rc++;
                checks++;
                if (mem_addr !== la[13:0]) begin errors++; $display("FAIL miss_mem_addr addr=%h got=%h exp=%h", a, mem_addr, la[13:0]); end
                mem_rdy  = (rc == d);
                mem_data = mem_rdy ? ln : {$urandom, $urandom};
            end else begin
                mem_rdy  = 1'($urandom_range(0, 1));
                mem_data = {$urandom, $urandom};
            end
            @(negedge clk);
            flush = (sc + 1 == fl_pos);
            #1;
        end
        mem_rdy = 1'b0;
        checks++; if (sc != d + 2) begin errors++; $display("FAIL miss_stall_cycles addr=%h got=%0d exp=%0d", a, sc, d + 2); end
        checks++; if (rc != d) begin errors++; $display("FAIL miss_mem_re_cycles addr=%h got=%0d exp=%0d", a, rc, d); end
        checks++; if (instr !== w) begin errors++; $display("FAIL miss_instr addr=%h got=%h exp=%h", a, instr, w); end
        checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL miss_mem_re_drop addr=%h got=%b exp=0", a, mem_re); end
        m_misses++;
        m_hits++;
        if (fl_pos > 0) model_clear_valid();
        mv[idx] = 1'b1; mt[idx] = tg; md[idx] = ln;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        rd_en = 1'b0; flush = 1'b0; mem_rdy = 1'b0; addr = 16'($urandom);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall got=%b exp=0", stall); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL idle_instr got=%h exp=0000", instr); end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0; rd_en = 1'b0; flush = 1'b0; mem_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear_valid();
        m_hits = 0; m_misses = 0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL rst_mem_re got=%b exp=0", mem_re); end
        checks++; if (mem_addr !== 14'h0) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0000", mem_addr); end
        checks++; if (stall !== 1'b0 || instr !== 16'h0) begin errors++; $display("FAIL rst_idle_out got=%b/%h exp=0/0000", stall, instr); end
        rd_en = 1'b1; addr = 16'h0012;
        #1;
        checks++; if (stall !== 1'b1 || instr !== 16'h0) begin errors++; $display("FAIL rst_cold_lookup got=%b/%h exp=1/0000", stall, instr); end
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear_valid();
    endtask

    task automatic test_cold_miss();
        mem_model[4] = {16'h4444, 16'hA5A5, 16'h2222, 16'h1111};
        access(16'h0012, 3, 0);
    endtask

    task automatic test_spatial_hit();
        access(16'h0013, 1, 0);
        checks++; if (instr !== 16'h4444) begin errors++; $display("FAIL spatial_word3 got=%h exp=4444", instr); end
    endtask

    task automatic test_conflict();
        access(16'h0010, 1, 0);
        access(16'h0030, 2, 0);
        access(16'h0010, 1, 0);
        access(16'h0030, 4, 0);
    endtask

    task automatic test_flush_miss();
        access(16'h0000, 1, 0);
        access(16'h0004, 2, 0);
        access(16'h0008, 3, 2);
        access(16'h000A, 1, 0);
        access(16'h0001, 1, 0);
        access(16'h0005, 1, 0);
        // flush sharing the FILL edge, then flush alongside an IDLE hit
        access(16'h0044, 2, 4);
        access(16'h0045, 1, 1);
        access(16'h0046, 1, 0);
    endtask

    task automatic test_reset_mid_miss();
        access(16'h0020, 1, 0);
        @(negedge clk);
        rd_en = 1'b1; addr = 16'h0064; mem_rdy = 1'b0; flush = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL midrst_pre_mem_re got=%b exp=1", mem_re); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL midrst_mem_re got=%b exp=0", mem_re); end
        checks++; if (mem_addr !== 14'h0) begin errors++; $display("FAIL midrst_mem_addr got=%h exp=0000", mem_addr); end
        rd_en = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall got=%b exp=0", stall); end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear_valid();
        m_hits = 0; m_misses = 0;
        mem_rdy = 1'b1; mem_data = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++; if (mem_re !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL midrst_stray_rdy got=%b/%b exp=0/0", mem_re, stall); end
        end
        mem_rdy = 1'b0;
        access(16'h0020, 2, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            logic [15:0] a;
            int          d;
            int          fp;
            a  = {11'($urandom_range(0, 2) * 11'h2A5), 3'($urandom), 2'($urandom)};
            d  = $urandom_range(1, 4);
            fp = ($urandom_range(0, 7) == 0) ? $urandom_range(1, d + 2) : 0;
            access(a, d, fp);
            if ($urandom_range(0, 5) == 0) idle_cycle();
        end
        access(16'hFFFF, 1, 0);
        access(16'hFFFC, 1, 0);
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        reset_dut();
        access(16'h0100, 2, 0);
        for (int i = 0; i < 4; i++) access(16'h0100 + 16'(i), 1, 0);
        #1;
        checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL stats_miss got=%0d exp=1", miss_cnt); end
        checks++; if (hit_cnt !== 16'd5) begin errors++; $display("FAIL stats_hit got=%0d exp=5", hit_cnt); end
        access(16'h0104, 1, 1);
        access(16'h0104, 1, 0);
        #1;
        checks++; if (hit_cnt !== 16'(m_hits) || miss_cnt !== 16'(m_misses)) begin errors++; $display("FAIL stats_model got=%0d/%0d exp=%0d/%0d", hit_cnt, miss_cnt, m_hits, m_misses); end
        @(negedge clk);
        rd_en = 1'b0;
        dut.hit_cnt_q = 16'hFFFD;
        for (int i = 0; i < 5; i++) access(16'h0104, 1, 0);
        #1;
        checks++; if (hit_cnt !== 16'hFFFF) begin errors++; $display("FAIL stats_saturate got=%h exp=FFFF", hit_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_spatial_hit();
        test_conflict();
        test_flush_miss();
        idle_cycle();
        test_reset_mid_miss();
        test_random();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
